// File: rtl/glitch_filter_if.sv
// Signal bundle for glitch_filter: raw inputs and controls in, filtered levels,
// edge/glitch pulses and the glitch counter out.
interface glitch_filter_if #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
);
   logic [CH-1:0]    din;
   logic             en;
   logic             clr_cnt;
   logic [CH-1:0]    dout;
   logic [CH-1:0]    rise;
   logic [CH-1:0]    fall;
   logic [CH-1:0]    glitch;
   logic [CNT_W-1:0] glitch_cnt;
   logic             cnt_sat;

   modport master (
      output din, en, clr_cnt,
      input  dout, rise, fall, glitch, glitch_cnt, cnt_sat
   );

   modport slave (
      input  din, en, clr_cnt,
      output dout, rise, fall, glitch, glitch_cnt, cnt_sat
   );
endinterface

// File: rtl/glitch_filter.sv
// Multi-channel glitch filter: optional 2-flop synchronizer, then a per-channel
// STABLE/PENDING machine that only accepts a level held for DEPTH enabled samples.
module glitch_filter #(
   parameter int CH    = 4,
   parameter int DEPTH = 3,
   parameter int SYNC  = 1,
   parameter int CNT_W = 8
) (
   input logic            clk,
   input logic            rst,
   glitch_filter_if.slave bus
);
   localparam int PC_W  = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + $clog2(CH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {STABLE, PENDING} state_t;

   logic [CH-1:0] smp;

   if (SYNC != 0) begin : g_sync
      logic [CH-1:0] meta_q;
      logic [CH-1:0] sync_q;

      // NOTE: flops use non-blocking assignments so meta_q->sync_q is a true
      // two-stage shift; a blocking '=' would collapse it into one stage.
      always_ff @(posedge clk) begin
         if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
         end else begin
            meta_q <= bus.din;
            sync_q <= meta_q;
         end
      end

      assign smp = sync_q;
   end else begin : g_direct
      assign smp = bus.din;
   end

   state_t           state_q [CH];
   state_t           state_d [CH];
   logic [PC_W-1:0]  pc_q    [CH];
   logic [PC_W-1:0]  pc_d    [CH];
   logic [CH-1:0]    dout_q, dout_d;
   logic [CH-1:0]    rise_q, rise_d;
   logic [CH-1:0]    fall_q, fall_d;
   logic [CH-1:0]    glitch_q, glitch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic [SUM_W-1:0] glitch_add;
   logic [SUM_W-1:0] cnt_sum;

   always_comb begin
      // NOTE: every signal gets a default before any branch; a path that leaves
      // one unassigned would infer a latch.
      dout_d     = dout_q;
      rise_d     = '0;
      fall_d     = '0;
      glitch_d   = '0;
      glitch_add = '0;
      cnt_sum    = '0;
      cnt_d      = cnt_q;
      sat_d      = sat_q;

      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         pc_d[i]    = pc_q[i];

         if (bus.en) begin
            case (state_q[i])
               STABLE: begin
                  if (smp[i] != dout_q[i]) begin
                     if (DEPTH == 1) begin
                        dout_d[i] = smp[i];
                        rise_d[i] = smp[i];
                        fall_d[i] = ~smp[i];
                     end else begin
                        pc_d[i]    = PC_W'(1);
                        state_d[i] = PENDING;
                     end
                  end
               end
               PENDING: begin
                  if (smp[i] == dout_q[i]) begin
                     glitch_d[i] = 1'b1;
                     pc_d[i]     = '0;
                     state_d[i]  = STABLE;
                  end else if (int'(pc_q[i]) + 1 == DEPTH) begin
                     dout_d[i]  = smp[i];
                     rise_d[i]  = smp[i];
                     fall_d[i]  = ~smp[i];
                     pc_d[i]    = '0;
                     state_d[i] = STABLE;
                  end else begin
                     pc_d[i] = pc_q[i] + PC_W'(1);
                  end
               end
               default: begin
                  pc_d[i]    = '0;
                  state_d[i] = STABLE;
               end
            endcase
         end

         glitch_add = glitch_add + SUM_W'(glitch_d[i]);
      end

      // The sum is wide enough to hold CNT_MAX plus every channel at once.
      cnt_sum = SUM_W'(cnt_q) + glitch_add;
      if (bus.clr_cnt) begin
         cnt_d = '0;
      end else if (cnt_sum > SUM_W'(CNT_MAX)) begin
         cnt_d = CNT_MAX;
      end else begin
         cnt_d = cnt_sum[CNT_W-1:0];
      end
      sat_d = (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the per-channel state/pc arrays are plain flops, not RAM, so
         // they are reset; an in-flight transition is simply dropped.
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= STABLE;
            pc_q[i]    <= '0;
         end
         dout_q   <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         glitch_q <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            pc_q[i]    <= pc_d[i];
         end
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.rise       = rise_q;
   assign bus.fall       = fall_q;
   assign bus.glitch     = glitch_q;
   assign bus.glitch_cnt = cnt_q;
   assign bus.cnt_sat    = sat_q;
endmodule
